// File: rtl/thermo_seq_ctrl_pkg.sv
// Shared definitions for the thermometer-counter sequencer.
//   - FSM state encoding
//   - program-entry field widths and bit offsets inside wr_data
//   - THERMO_W: width of the thermometer code being monitored
// The entry layout is {ld_en, ld_val[3:0], mode[1:0], dwell[DWELL_W-1:0]},
// so offsets depend on DWELL_W and are provided as constant functions.
package thermo_seq_ctrl_pkg;

  localparam int THERMO_W = 15;

  localparam int MODE_W  = 2;
  localparam int LDVAL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int f_dwell_lsb(input int dwell_w);
    return 0;
  endfunction

  function automatic int f_mode_lsb(input int dwell_w);
    return dwell_w;
  endfunction

  function automatic int f_ldval_lsb(input int dwell_w);
    return dwell_w + MODE_W;
  endfunction

  function automatic int f_lden_bit(input int dwell_w);
    return dwell_w + MODE_W + LDVAL_W;
  endfunction

  function automatic int f_entry_w(input int dwell_w);
    return dwell_w + MODE_W + LDVAL_W + 1;
  endfunction

endpackage

// File: rtl/thermo_seq_ctrl_thermo_check.sv
// Combinational legality check of a thermometer code.
//   code  : THERMO_W-bit thermometer value from the counter
//   legal : 1 when code has the form 2^k-1 (all ones packed at the LSB end,
//           including all-zero), 0 otherwise
module thermo_check
  import thermo_seq_ctrl_pkg::*;
(
  input  logic [THERMO_W-1:0] code,
  output logic                legal
);

  // A value of the form 2^k-1 has no bit in common with its successor.
  logic [THERMO_W-1:0] code_inc;

  assign code_inc = code + THERMO_W'(1);
  assign legal    = ((code & code_inc) == '0);

endmodule

// File: rtl/thermo_seq_ctrl.sv
// Program sequencer driving a thermometer counter.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data: program-entry write {ld_en, ld_val, mode, dwell}
//   last_step            : index of the final entry executed
//   loop_en              : wrap to entry 0 after last_step instead of finishing
//   start, abort         : begin / stop the program
//   thermo_count         : thermometer code returned by the counter
//   mode, load, in       : counter controls
//   busy, done, step     : sequencer status
//   thermo_err           : sticky illegal-code flag
module thermo_seq_ctrl
  import thermo_seq_ctrl_pkg::*;
#(
  parameter  int NUM_STEPS = 4,
  parameter  int DWELL_W   = 8,
  localparam int STEP_W    = $clog2(NUM_STEPS),
  localparam int ENTRY_W   = DWELL_W + 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [STEP_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]  wr_data,
  input  logic [STEP_W-1:0]   last_step,
  input  logic                loop_en,
  input  logic                start,
  input  logic                abort,
  input  logic [THERMO_W-1:0] thermo_count,
  output logic [1:0]          mode,
  output logic                load,
  output logic [3:0]          in,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   step,
  output logic                thermo_err
);

  localparam int DWELL_LSB = f_dwell_lsb(DWELL_W);
  localparam int MODE_LSB  = f_mode_lsb(DWELL_W);
  localparam int LDVAL_LSB = f_ldval_lsb(DWELL_W);
  localparam int LDEN_BIT  = f_lden_bit(DWELL_W);

  logic [ENTRY_W-1:0] prog_mem [NUM_STEPS];

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [1:0]          mode_q;
  logic                err_q;
  logic                load_prev_q;
  logic                start_ok;

  logic [STEP_W-1:0]   eff_last;
  logic                addr_ok;
  logic [STEP_W-1:0]   nxt_idx;
  logic                nxt_ld;
  logic                ent0_ld;
  logic [1:0]          cur_mode;
  logic [3:0]          cur_ldval;
  logic [DWELL_W-1:0]  cur_dwell;
  logic [DWELL_W-1:0]  dwell_m1;
  logic                run_end;
  logic                can_write;
  logic                legal;

  // An out-of-range last_step clamps to the final entry; out-of-range write
  // addresses are dropped. Both cases only exist when NUM_STEPS is not a
  // power of two.
  if (NUM_STEPS == (1 << STEP_W)) begin : g_pow2
    assign eff_last = last_step;
    assign addr_ok  = 1'b1;
  end else begin : g_npow2
    assign eff_last = ({1'b0, last_step} >= (STEP_W+1)'(NUM_STEPS)) ?
                      STEP_W'(NUM_STEPS - 1) : last_step;
    assign addr_ok  = ({1'b0, wr_addr} < (STEP_W+1)'(NUM_STEPS));
  end

  thermo_check u_check (
    .code  (thermo_count),
    .legal (legal)
  );

  assign can_write = (state_q == ST_IDLE) || (state_q == ST_DONE);

  assign cur_mode  = prog_mem[step_q][MODE_LSB  +: MODE_W];
  assign cur_ldval = prog_mem[step_q][LDVAL_LSB +: LDVAL_W];
  assign cur_dwell = prog_mem[step_q][DWELL_LSB +: DWELL_W];

  // A dwell of zero runs for one cycle, same as a dwell of one.
  assign dwell_m1  = (cur_dwell == '0) ? '0 : cur_dwell - DWELL_W'(1);
  assign run_end   = (cnt_q >= dwell_m1);

  assign nxt_idx   = (step_q == eff_last) ? '0 : step_q + STEP_W'(1);
  assign nxt_ld    = prog_mem[nxt_idx][LDEN_BIT];

  // A write to entry 0 in the same cycle as start must steer the first
  // transition, so bypass the array for that bit.
  assign ent0_ld   = (wr_en && can_write && addr_ok && (wr_addr == '0)) ?
                     wr_data[LDEN_BIT] : prog_mem[0][LDEN_BIT];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode;
      load_prev_q <= (state_q == ST_LOAD);
      if (start_ok) begin
        err_q <= 1'b0;
      end else if (busy && !legal && !load_prev_q) begin
        // The counter needs one cycle to reflect a load, so skip that cycle.
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        prog_mem[i] <= '0;
      end
    end else if (wr_en && can_write && addr_ok) begin
      prog_mem[wr_addr] <= wr_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          step_d   = '0;
          cnt_d    = '0;
          state_d  = ent0_ld ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_end) begin
          cnt_d = '0;
          if ((step_q == eff_last) && !loop_en) begin
            state_d = ST_DONE;
          end else begin
            step_d  = nxt_idx;
            state_d = nxt_ld ? ST_LOAD : ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      step_d   = step_q;
      cnt_d    = '0;
      start_ok = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    load = (state_q == ST_LOAD) && !abort;
    in   = (state_q == ST_LOAD) ? cur_ldval : 4'd0;
    mode = busy ? cur_mode : mode_q;
  end

  assign step       = step_q;
  assign thermo_err = err_q;

endmodule

// File: tb/tb_thermo_seq_ctrl.sv
module tb_thermo_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [14:0] wr_data;
  logic [1:0]  last_step;
  logic        loop_en;
  logic        start;
  logic        abort;
  logic [14:0] thermo_count;
  logic [1:0]  mode;
  logic        load;
  logic [3:0]  in_v;
  logic        busy;
  logic        done;
  logic [1:0]  step;
  logic        thermo_err;

  always #5 clk = ~clk;

  thermo_seq_ctrl #(.NUM_STEPS(4), .DWELL_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .last_step    (last_step),
    .loop_en      (loop_en),
    .start        (start),
    .abort        (abort),
    .thermo_count (thermo_count),
    .mode         (mode),
    .load         (load),
    .in           (in_v),
    .busy         (busy),
    .done         (done),
    .step         (step),
    .thermo_err   (thermo_err)
  );

  // One expected output record per cycle of a running program.
  typedef struct {
    bit       busy;
    bit       done;
    bit       load;
    bit [3:0] val;
    bit [1:0] mode;
    bit [1:0] step;
  } exp_t;

  exp_t        q[$];
  bit [14:0]   m_prog [4];
  bit          m_err;
  bit          m_loadprev;
  bit [1:0]    m_mode;
  bit [1:0]    m_step;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input bit [14:0] v);
    for (int k = 0; k <= 15; k++) begin
      if (v == 15'((32'd1 << k) - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < 4; i++) m_prog[i] = '0;
    m_err      = 1'b0;
    m_loadprev = 1'b0;
    m_mode     = '0;
    m_step     = '0;
  endtask

  // Expand the stored program into its cycle-by-cycle output schedule.
  task automatic build(input int last, input bit lp);
    do begin
      for (int s = 0; s <= last; s++) begin
        exp_t r;
        int   dw;
        r.busy = 1'b1;
        r.done = 1'b0;
        r.step = 2'(s);
        r.mode = m_prog[s][9:8];
        r.val  = m_prog[s][13:10];
        if (m_prog[s][14]) begin
          r.load = 1'b1;
          q.push_back(r);
        end
        r.load = 1'b0;
        dw = int'(m_prog[s][7:0]);
        if (dw == 0) dw = 1;
        for (int c = 0; c < dw; c++) q.push_back(r);
      end
    end while (lp && q.size() < 400);
    if (!lp) begin
      exp_t d;
      d.busy = 1'b0;
      d.done = 1'b1;
      d.load = 1'b0;
      d.val  = '0;
      d.mode = '0;
      d.step = 2'(last);
      q.push_back(d);
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t r;
    if (q.size() > 0) begin
      r = q[0];
    end else begin
      r.busy = 1'b0;
      r.done = 1'b0;
      r.load = 1'b0;
      r.val  = '0;
      r.mode = m_mode;
      r.step = m_step;
    end
    return r;
  endfunction

  // Compare all outputs against the model, #1 after the falling edge.
  task automatic settle();
    exp_t r;
    #1;
    r = cur_exp();
    chk("mode",       mode,       r.busy ? r.mode : m_mode);
    chk("load",       load,       r.busy && r.load && !abort);
    chk("in",         in_v,       (r.busy && r.load) ? r.val : 4'd0);
    chk("busy",       busy,       r.busy);
    chk("done",       done,       r.done);
    chk("step",       step,       r.step);
    chk("thermo_err", thermo_err, m_err);
  endtask

  // Advance the model across the coming rising edge, then wait for negedge.
  task automatic advance();
    exp_t r;
    bit   act;
    r   = cur_exp();
    act = (q.size() > 0);
    if (r.busy && !is_legal(thermo_count) && !m_loadprev) m_err = 1'b1;
    m_loadprev = r.busy && r.load;
    if (r.busy) m_mode = r.mode;
    if (act) m_step = r.step;
    if (wr_en && !r.busy) m_prog[wr_addr] = wr_data;
    if (act) begin
      if (abort) q.delete();
      else void'(q.pop_front());
    end else if (start && !abort) begin
      m_err  = 1'b0;
      m_step = '0;
      build(int'(last_step), loop_en);
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic quiet();
    wr_en = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    quiet();
    wr_addr      = '0;
    wr_data      = '0;
    last_step    = '0;
    loop_en      = 1'b0;
    thermo_count = '0;
    m_reset();
    #2;
    chk("rst_mode", mode, 0);
    chk("rst_load", load, 0);
    chk("rst_in",   in_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    chk("rst_err",  thermo_err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single load entry, write and start in the same cycle.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {1'b1, 4'd11, 2'b00, 8'd5}; start = 1'b1;
    tick();
    quiet();
    settle(); chk("p1_load", load, 1); chk("p1_in", in_v, 11); chk("p1_busy", busy, 1); advance();
    for (int i = 0; i < 5; i++) begin
      settle(); chk("p1_run_busy", busy, 1); chk("p1_run_mode", mode, 0); chk("p1_run_load", load, 0); advance();
    end
    settle(); chk("p1_done", done, 1); chk("p1_done_busy", busy, 0); advance();
    settle(); chk("p1_after_done", done, 0); advance();

    // Four entries, modes 0..3, dwell 3.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = {1'b0, 4'd0, 2'(i), 8'd3};
      tick();
    end
    quiet();
    last_step = 2'd3; loop_en = 1'b0; start = 1'b1;
    tick();
    quiet();
    for (int i = 0; i < 12; i++) begin
      settle(); chk("p2_mode", mode, i / 3); chk("p2_step", step, i / 3); advance();
    end
    settle(); chk("p2_done", done, 1); advance();
    settle(); chk("p2_once", done, 0); advance();

    // Same program looping, aborted during step 2.
    loop_en = 1'b1; start = 1'b1;
    tick();
    quiet();
    for (int i = 0; i < 6; i++) tick();
    abort = 1'b1;
    settle(); chk("p3_step2", step, 2); advance();
    abort = 1'b0;
    settle(); chk("p3_abort_busy", busy, 0); chk("p3_abort_done", done, 0); advance();
    for (int i = 0; i < 3; i++) tick();
    loop_en = 1'b0;

    // Dwell 0, restart attempt while busy.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {1'b0, 4'd0, 2'b10, 8'd0}; last_step = 2'd0;
    tick();
    quiet();
    start = 1'b1;
    tick();
    settle(); chk("p4_busy", busy, 1); chk("p4_mode", mode, 2); advance();
    start = 1'b0;
    settle(); chk("p4_done", done, 1); advance();
    settle(); chk("p4_no_restart", busy, 0); chk("p4_mode_hold", mode, 2); advance();

    // Illegal thermometer code while busy.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {1'b1, 4'd3, 2'b01, 8'd4};
    tick();
    quiet();
    thermo_count = 15'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    settle(); chk("p5_err_done", thermo_err, 1); chk("p5_done", done, 1); advance();
    thermo_count = '0;
    settle(); chk("p5_err_idle", thermo_err, 1); advance();
    start = 1'b1;
    tick();
    start = 1'b0;
    settle(); chk("p5_err_clr", thermo_err, 0); advance();
    for (int i = 0; i < 7; i++) tick();

    // Asynchronous reset in the middle of RUN.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {1'b0, 4'd0, 2'b11, 8'd9};
    tick();
    quiet();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    #1;
    chk("ar_mode", mode, 0);
    chk("ar_load", load, 0);
    chk("ar_in",   in_v, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_step", step, 0);
    chk("ar_err",  thermo_err, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0) begin
        last_step = 2'($urandom);
        loop_en   = ($urandom_range(0, 3) == 0);
      end
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom);
      wr_data = {1'($urandom), 4'($urandom), 2'($urandom), 8'($urandom_range(0, 6))};
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 24) == 0) || (loop_en && q.size() > 0 && q.size() < 12);
      if ($urandom_range(0, 7) == 0) thermo_count = 15'($urandom);
      else thermo_count = 15'((32'd1 << $urandom_range(0, 15)) - 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermo_seq_ctrl.md
THERMO_SEQ_CTRL -- requirements
Module: thermo_seq_ctrl

Interface
REQ-001 Parameter NUM_STEPS, default 4: number of program entries.
REQ-002 Parameter DWELL_W, default 8: width of the per-step dwell counter.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  program-entry write strobe.
REQ-006 wr_addr  input  $clog2(NUM_STEPS)  entry index to write.
REQ-007 wr_data  input  7+DWELL_W  fields: {ld_en[1], ld_val[4], mode[2], dwell[DWELL_W]}.
REQ-008 last_step  input  $clog2(NUM_STEPS)  index of the final entry executed.
REQ-009 loop_en  input  1  restart at entry 0 after last_step instead of finishing.
REQ-010 start  input  1  one-cycle request to begin the program.
REQ-011 abort  input  1  stop the program immediately.
REQ-012 thermo_count  input  15  thermometer output of the counter under control.
REQ-013 mode  output  2  mode code driven to the counter.
REQ-014 load  output  1  load strobe to the counter.
REQ-015 in  output  4  load value to the counter.
REQ-016 busy  output  1  high while the program runs.
REQ-017 done  output  1  one-cycle pulse when the program completes.
REQ-018 step  output  $clog2(NUM_STEPS)  index of the current entry.
REQ-019 thermo_err  output  1  sticky flag: illegal thermometer code seen while busy.

Function
REQ-020 FSM states: IDLE, LOAD, RUN, DONE.
REQ-021 IDLE + start: step<=0; next state LOAD if entry0.ld_en, else RUN.
REQ-022 LOAD lasts exactly one cycle: load=1, in=ld_val, mode=entry.mode; then RUN.
REQ-023 RUN holds mode=entry.mode and load=0 for max(dwell,1) cycles; dwell=0 is treated as 1.
REQ-024 End of RUN with step<last_step: step+1; next state LOAD or RUN according to the new entry's ld_en.
REQ-025 End of RUN with step==last_step: if loop_en, step<=0 and continue; otherwise go to DONE.
REQ-026 DONE lasts one cycle: done=1, busy=0; then IDLE.
REQ-027 busy is 1 in LOAD and RUN only.
REQ-028 When last_step>=NUM_STEPS, the sequence ends at entry NUM_STEPS-1.
REQ-029 start while busy is ignored.
REQ-030 abort has priority over start and all transitions: next state IDLE, load=0, no done pulse.
REQ-031 A write while busy is ignored; a write in IDLE/DONE updates the entry on the next edge.
REQ-032 A write and a start in the same IDLE cycle: the write takes effect, and the program reads the new value.
REQ-033 In IDLE and DONE: mode holds its last driven value, load=0, in=0.
REQ-034 Legal thermo_count = 2^k-1 for k in 0..15.
REQ-035 thermo_err sets in any busy cycle with illegal thermo_count, except the cycle after a load.
REQ-036 thermo_err clears on an accepted start.

Reset
REQ-037 On reset: state=IDLE, mode=2'b00, load=0, in=0, busy=0, done=0, step=0, thermo_err=0, dwell counter=0.
REQ-038 Program entries reset to all-zero: ld_en=0, mode=00, dwell=0.
REQ-039 Reset mid-program returns to IDLE asynchronously, with no done pulse.

Structure
REQ-040 A shared package holds: the FSM state encoding, the wr_data field offsets/widths, and THERMO_W=15.
REQ-041 One sub-module, thermo_check: a combinational legality check of a THERMO_W-bit thermometer code.

Verification
REQ-042 Program entry0={ld 1, val 11, mode 00, dwell 5}; last_step=0; start -> load=1/in=11 for 1 cycle, mode=00 for 5 cycles, then done pulse; busy high for 6 cycles.
REQ-043 Program 4 entries with modes 00,01,10,11, dwell 3, ld_en=0; last_step=3 -> mode sequence 00x3, 01x3, 10x3, 11x3; step 0..3; done once.
REQ-044 Same program with loop_en=1; assert abort during step 2 -> IDLE next cycle, busy=0, no done pulse.
REQ-045 dwell=0 entry -> RUN lasts 1 cycle; start pulsed while busy -> no restart.
REQ-046 Drive thermo_count=15'h0005 while busy -> thermo_err=1 and stays set through done; next start -> thermo_err=0.
REQ-047 Assert reset mid-RUN -> all outputs at reset values immediately, without waiting for a clk edge.
